// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory stage: FSM encoding and word geometry.
package dmem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_OFF_W = $clog2(WORD_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // True when the byte offset selects the first byte of a word.
    function automatic logic is_aligned(input logic [BYTE_OFF_W-1:0] byte_off);
        return byte_off == '0;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-wide SRAM model: synchronous write, asynchronous read, no reset.
module sram_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Data-memory stage: wait-state FSM in front of a word SRAM, with load register,
// sticky misalignment flag and a stall to freeze the pipeline during an access.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MisalignErr
);

    localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_LSB   = BYTE_OFF_W;
    localparam int unsigned IDX_MSB   = DEPTH_LOG2 + BYTE_OFF_W - 1;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam bit          SKIP_WAIT = (WAIT_CYCLES == 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  req;
    logic                  aligned_req;
    logic                  mem_we;
    logic                  stall_c;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  unused_addr_hi;

    assign req         = MemRead | MemWrite;
    assign aligned_req = req & is_aligned(Addr[BYTE_OFF_W-1:0]);
    assign idx         = Addr[IDX_MSB:IDX_LSB];

    // Address bits above the array depth wrap and are intentionally ignored.
    assign unused_addr_hi = ^Addr[ADDR_W-1:IDX_MSB+1];

    sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .CLK   (CLK),
        .we    (mem_we),
        .addr  (idx),
        .wdata (WriteData),
        .rdata (mem_rdata)
    );

    // The request cycle in IDLE is the first stall cycle, so WAIT is left one
    // count early and the CPU sees exactly WAIT_CYCLES stalled cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        stall_c = 1'b0;

        if (req && !aligned_req) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (aligned_req) begin
                    if (ZERO_WAIT) begin
                        mem_we = MemWrite;
                        if (!MemWrite) begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CNT_LOAD;
                        if (SKIP_WAIT) begin
                            state_d = S_DONE;
                            if (!MemWrite) begin
                                rdata_d = mem_rdata;
                            end
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (!aligned_req) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    if (!MemWrite) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                mem_we  = aligned_req & MemWrite;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset suppresses the stall and discards any pending store.
        if (!reset) begin
            stall_c = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ReadData    = rdata_q;
    assign Stall       = stall_c;
    assign MisalignErr = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a 2-wait-state instance and a zero-wait instance.
module tb_data_memory_ctrl;

    logic        CLK = 1'b0;
    logic        reset;

    logic        mem_read, mem_write;
    logic [31:0] addr, wdata, read_data;
    logic        stall, err;

    logic        z_read, z_write;
    logic [31:0] z_addr, z_wdata, z_read_data;
    logic        z_stall, z_err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut (
        .CLK         (CLK),
        .reset       (reset),
        .MemRead     (mem_read),
        .MemWrite    (mem_write),
        .Addr        (addr),
        .WriteData   (wdata),
        .ReadData    (read_data),
        .Stall       (stall),
        .MisalignErr (err)
    );

    data_memory_ctrl #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_zw (
        .CLK         (CLK),
        .reset       (reset),
        .MemRead     (z_read),
        .MemWrite    (z_write),
        .Addr        (z_addr),
        .WriteData   (z_wdata),
        .ReadData    (z_read_data),
        .Stall       (z_stall),
        .MisalignErr (z_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Full 2-wait-state access: stall in IDLE and WAIT, low in DONE, then release.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        #1;
        check({tag, "_stall_idle"}, 32'(stall), 32'd1);
        step();
        check({tag, "_stall_wait"}, 32'(stall), 32'd1);
        step();
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        if (rd && !wr) begin
            check({tag, "_rdata"}, read_data, exp_rd);
        end
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        check({tag, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        z_read = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0;
        mem_read = 1'b0; addr = '0;

        // Reset held with a store asserted.
        reset = 1'b0; mem_write = 1'b1; wdata = 32'h0000_0BAD;
        #1;
        step();
        check("rst_stall_c1", 32'(stall), 32'd0);
        step();
        check("rst_stall_c2", 32'(stall), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_zw_rdata", z_read_data, 32'd0);
        mem_write = 1'b0;
        reset = 1'b1;
        step();

        // A store under reset must not land in the array.
        access("st0", 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0);
        reset = 1'b0; mem_write = 1'b1; addr = 32'h0; wdata = 32'h0000_0BAD;
        step();
        step();
        mem_write = 1'b0; reset = 1'b1;
        step();
        access("ld0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111);

        access("st10", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        access("ld10", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);

        // Upper address bits wrap onto word 1.
        access("st4", 1'b0, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 32'h0);
        access("ld404", 1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'hA5A5_0004);

        // Misaligned load.
        mem_read = 1'b1; addr = 32'h0000_0013;
        #1;
        check("mis_stall0", 32'(stall), 32'd0);
        step();
        check("mis_err", 32'(err), 32'd1);
        check("mis_stall1", 32'(stall), 32'd0);
        check("mis_rdata", read_data, 32'hA5A5_0004);
        mem_read = 1'b0;
        step();
        check("mis_err_sticky", 32'(err), 32'd1);

        // Store dropped in WAIT leaves memory untouched.
        mem_write = 1'b1; addr = 32'h0000_0010; wdata = 32'h0000_0077;
        step();
        mem_write = 1'b0;
        #1;
        check("drop_stall_wait", 32'(stall), 32'd1);
        step();
        check("drop_stall_idle", 32'(stall), 32'd0);
        access("ld10b", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        check("mis_err_still", 32'(err), 32'd1);

        // Reset during WAIT discards the pending store.
        access("st20", 1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0);
        mem_write = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_0055;
        step();
        reset = 1'b0;
        #1;
        check("rstw_stall", 32'(stall), 32'd0);
        step();
        mem_write = 1'b0; reset = 1'b1;
        #1;
        check("rstw_rdata", read_data, 32'd0);
        check("rstw_err", 32'(err), 32'd0);
        check("rstw_stall_idle", 32'(stall), 32'd0);
        access("ld20", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_1234);

        // Zero-wait instance: store then load on consecutive cycles.
        z_write = 1'b1; z_addr = 32'h0000_0008; z_wdata = 32'hCAFE_0008;
        #1;
        check("zw_stall_st", 32'(z_stall), 32'd0);
        step();
        z_write = 1'b0; z_read = 1'b1;
        #1;
        check("zw_stall_ld", 32'(z_stall), 32'd0);
        check("zw_rdata_pre", z_read_data, 32'd0);
        step();
        z_read = 1'b0;
        #1;
        check("zw_rdata", z_read_data, 32'hCAFE_0008);
        check("zw_stall_post", 32'(z_stall), 32'd0);
        check("zw_err", 32'(z_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
